// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU: operation codes, controller states
// and a small operation-class helper.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } ser_state_e;

    function automatic logic is_arith(input alu_op_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_1bit.sv
// One-bit ALU slice: AND / OR / full-add / full-subtract on a single bit pair.
module alu_1bit
    import alu_pkg::*;
(
    input  logic    a,
    input  logic    b,
    input  logic    cin,
    input  alu_op_e op,
    output logic    z,
    output logic    cout
);

    // Per-bit result and carry for the selected operation
    always_comb begin
        z    = 1'b0;
        cout = 1'b0;
        case (op)
            OP_AND: begin
                z    = a & b;
                cout = 1'b0;
            end
            OP_OR: begin
                z    = a | b;
                cout = 1'b0;
            end
            OP_ADD: begin
                z    = a ^ b ^ cin;
                cout = (a & b) | (a & cin) | (b & cin);
            end
            OP_SUB: begin
                z    = a ^ ~b ^ cin;
                cout = (a & ~b) | (a & cin) | (~b & cin);
            end
            default: begin
                z    = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: streams an operand pair LSB-first through one
// alu_1bit slice and returns the WIDTH-bit result on a valid/ready handshake.
module alu_serial_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       s_op,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             busy
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    ser_state_e       state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic             carry_q,  carry_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    alu_op_e          op_q,     op_d;

    alu_op_e          in_op_s;
    alu_op_e          slice_op_s;
    logic             slice_b_s;
    logic             slice_z_s;
    logic             slice_cout_s;

    // Subtraction runs as a + ~b + 1, so the slice always sees the ADD code for it
    always_comb begin
        in_op_s = alu_op_e'(s_op);
        if (op_q == OP_SUB) begin
            slice_op_s = OP_ADD;
            slice_b_s  = ~b_sh_q[0];
        end else begin
            slice_op_s = op_q;
            slice_b_s  = b_sh_q[0];
        end
    end

    alu_1bit u_slice (
        .a    (a_sh_q[0]),
        .b    (slice_b_s),
        .cin  (carry_q),
        .op   (slice_op_s),
        .z    (slice_z_s),
        .cout (slice_cout_s)
    );

    // Next-state and datapath update for the IDLE/RUN/DONE sequence
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    op_d    = in_op_s;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_RUN;
                    case (in_op_s)
                        OP_ADD:  carry_d = cin;
                        OP_SUB:  carry_d = 1'b1;
                        default: carry_d = 1'b0;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                res_sh_d = {slice_z_s, res_sh_q[WIDTH-1:1]};
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                carry_d  = slice_cout_s;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= {WIDTH{1'b0}};
            b_sh_q   <= {WIDTH{1'b0}};
            res_sh_q <= {WIDTH{1'b0}};
            carry_q  <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
            op_q     <= OP_AND;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
        end
    end

    // Outputs decode only registered state, so no input reaches them combinationally
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
        result    = res_sh_q;
        cout      = carry_q & is_arith(op_q);
    end

endmodule
